// File: rtl/nios_dbg_pkg.sv
// Shared types and constants for the Nios II debug scan slave.
// Status bits sit at the top of the capture word, addressed as offsets from the MSB.
package nios_dbg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int STAT_LEN_ERR_OFS = 0;
    localparam int STAT_OVERRUN_OFS = 1;

    // Counter must represent DR_WIDTH+1 so over-long scans are distinguishable.
    function automatic int shift_cnt_w(input int dr_width);
        return $clog2(dr_width + 2);
    endfunction

endpackage

// File: rtl/nios_dbg_action_slot.sv
// One-deep valid/ready holding register for the update word and its channel.
// Load visible one cycle after push; full only while valid and not being accepted.
module nios_dbg_action_slot
    import nios_dbg_pkg::*;
#(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_push,
    input  logic [DR_WIDTH-1:0] i_dat,
    input  logic [IR_WIDTH-1:0] i_ch,
    output logic                o_full,
    output logic                o_vld,
    input  logic                i_rdy,
    output logic [DR_WIDTH-1:0] o_dat,
    output logic [IR_WIDTH-1:0] o_ch
);

    logic                r_vld;
    logic [DR_WIDTH-1:0] r_dat;
    logic [IR_WIDTH-1:0] r_ch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= 1'b0;
            r_dat <= '0;
            r_ch  <= '0;
        end else begin
            if (i_push) begin
                r_vld <= 1'b1;
                r_dat <= i_dat;
                r_ch  <= i_ch;
            end else if (r_vld && i_rdy) begin
                r_vld <= 1'b0;
            end
        end
    end

    // An accepting consumer frees the slot in time for a same-cycle refill.
    assign o_full = r_vld & ~i_rdy;
    assign o_vld  = r_vld;
    assign o_dat  = r_dat;
    assign o_ch   = r_ch;

endmodule

// File: rtl/nios_dbg_scan_slave.sv
// Debug scan slave: decodes virtual-JTAG strobes, captures channel status, shifts TDI/TDO.
// Updates land one cycle after udr; a full slot drops the update and flags overrun.
module nios_dbg_scan_slave
    import nios_dbg_pkg::*;
#(
    parameter  int DR_WIDTH = 38,
    parameter  int IR_WIDTH = 2,
    localparam int NUM_CH   = 2 ** IR_WIDTH,
    localparam int CAP_W    = DR_WIDTH - 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scan_en,
    input  logic                      vs_uir,
    input  logic                      vs_cdr,
    input  logic                      vs_sdr,
    input  logic                      vs_udr,
    input  logic                      jtag_state_rti,
    input  logic [IR_WIDTH-1:0]       ir_in,
    input  logic                      tdi,
    input  logic [NUM_CH*CAP_W-1:0]   capture_data,
    input  logic                      action_ready,
    output logic                      tdo,
    output logic [DR_WIDTH-1:0]       jdo,
    output logic                      action_valid,
    output logic [IR_WIDTH-1:0]       action_ch,
    output logic                      st_ready_test_idle
);

    localparam int CNT_W   = shift_cnt_w(DR_WIDTH);
    localparam int LEN_POS = DR_WIDTH - 1 - STAT_LEN_ERR_OFS;
    localparam int OVR_POS = DR_WIDTH - 1 - STAT_OVERRUN_OFS;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IR_WIDTH-1:0] r_ir_q;
    logic [DR_WIDTH-1:0] r_sr;
    logic [CNT_W-1:0]    r_shift_cnt;
    logic                r_len_err;
    logic                r_overrun;
    logic                r_st_ready;

    logic                w_uir;
    logic                w_udr;
    logic                w_cdr;
    logic                w_sdr;
    logic                w_shift_en;
    logic                w_push;
    logic                w_set_len;
    logic                w_set_ovr;
    logic                w_slot_full;
    logic [CAP_W-1:0]    w_cap_slice;
    logic [DR_WIDTH-1:0] w_cap_word;

    // Fixed priority uir > udr > cdr > sdr; only the winner acts.
    assign w_uir = scan_en & vs_uir;
    assign w_udr = scan_en & vs_udr & ~vs_uir;
    assign w_cdr = scan_en & vs_cdr & ~vs_uir & ~vs_udr;
    assign w_sdr = scan_en & vs_sdr & ~vs_uir & ~vs_udr & ~vs_cdr;
    assign w_shift_en = w_sdr & (r_state == SHIFT);

    assign w_cap_slice = capture_data[int'(r_ir_q) * CAP_W +: CAP_W];

    always_comb begin
        w_cap_word             = '0;
        w_cap_word[CAP_W-1:0]  = w_cap_slice;
        w_cap_word[LEN_POS]    = r_len_err;
        w_cap_word[OVR_POS]    = r_overrun;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_set_len   = 1'b0;
        w_set_ovr   = 1'b0;
        if (w_uir) begin
            w_state_nxt = IDLE;
        end else if (w_udr) begin
            if (r_state == SHIFT) begin
                w_state_nxt = IDLE;
                if (r_shift_cnt != CNT_W'(DR_WIDTH)) w_set_len = 1'b1;
                else if (w_slot_full)                w_set_ovr = 1'b1;
                else                                 w_push    = 1'b1;
            end
        end else if (w_cdr) begin
            w_state_nxt = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_q      <= '0;
            r_sr        <= '0;
            r_shift_cnt <= '0;
            r_len_err   <= 1'b0;
            r_overrun   <= 1'b0;
            r_st_ready  <= 1'b0;
        end else begin
            if (w_uir) r_ir_q <= ir_in;

            if (w_cdr) begin
                r_sr        <= w_cap_word;
                r_shift_cnt <= '0;
            end else if (w_shift_en) begin
                r_sr <= {tdi, r_sr[DR_WIDTH-1:1]};
                if (r_shift_cnt != '1) r_shift_cnt <= r_shift_cnt + CNT_W'(1);
            end

            // Capture reports the flags, so it also clears them; a set still wins.
            if (w_set_len)  r_len_err <= 1'b1;
            else if (w_cdr) r_len_err <= 1'b0;
            if (w_set_ovr)  r_overrun <= 1'b1;
            else if (w_cdr) r_overrun <= 1'b0;

            r_st_ready <= jtag_state_rti & ~action_valid;
        end
    end

    nios_dbg_action_slot #(
        .DR_WIDTH (DR_WIDTH),
        .IR_WIDTH (IR_WIDTH)
    ) u_slot (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_push),
        .i_dat  (r_sr),
        .i_ch   (r_ir_q),
        .o_full (w_slot_full),
        .o_vld  (action_valid),
        .i_rdy  (action_ready),
        .o_dat  (jdo),
        .o_ch   (action_ch)
    );

    assign tdo                = r_sr[0];
    assign st_ready_test_idle = r_st_ready;

endmodule

// File: tb/tb_nios_dbg_scan_slave.sv
// Directed bench for nios_dbg_scan_slave: scans, updates, flags, handshake and reset.
module tb_nios_dbg_scan_slave;

    localparam int DW = 38;
    localparam int IW = 2;
    localparam int CW = DW - 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            scan_en;
    logic            vs_uir, vs_cdr, vs_sdr, vs_udr;
    logic            jtag_state_rti;
    logic [IW-1:0]   ir_in;
    logic            tdi;
    logic [4*CW-1:0] capture_data;
    logic            action_ready;
    logic            tdo;
    logic [DW-1:0]   jdo;
    logic            action_valid;
    logic [IW-1:0]   action_ch;
    logic            st_ready_test_idle;

    int total = 0;
    int bad   = 0;

    localparam logic [DW-1:0] WORD_A = 38'h11_2233_4455;
    localparam logic [DW-1:0] WORD_B = 38'h3C_0F0F_0F0F;
    localparam logic [DW-1:0] WORD_C = 38'h05_DEAD_BEEF;
    localparam logic [DW-1:0] WORD_D = 38'h1E_1234_5678;
    localparam logic [DW-1:0] WORD_E = 38'h27_8765_4321;

    always #5 clk = ~clk;

    nios_dbg_scan_slave #(.DR_WIDTH(DW), .IR_WIDTH(IW)) dut (
        .clk                (clk),
        .reset              (reset),
        .scan_en            (scan_en),
        .vs_uir             (vs_uir),
        .vs_cdr             (vs_cdr),
        .vs_sdr             (vs_sdr),
        .vs_udr             (vs_udr),
        .jtag_state_rti     (jtag_state_rti),
        .ir_in              (ir_in),
        .tdi                (tdi),
        .capture_data       (capture_data),
        .action_ready       (action_ready),
        .tdo                (tdo),
        .jdo                (jdo),
        .action_valid       (action_valid),
        .action_ch          (action_ch),
        .st_ready_test_idle (st_ready_test_idle)
    );

    task automatic pulse(input logic u, input logic d, input logic c, input logic s, input logic t);
        scan_en = 1'b1; vs_uir = u; vs_udr = d; vs_cdr = c; vs_sdr = s; tdi = t;
        @(posedge clk); #1;
        scan_en = 1'b0; vs_uir = 1'b0; vs_udr = 1'b0; vs_cdr = 1'b0; vs_sdr = 1'b0; tdi = 1'b0;
    endtask

    task automatic do_uir(input logic [IW-1:0] ch);
        ir_in = ch;
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_cdr;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_sdr(input logic t);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, t);
    endtask

    task automatic do_udr;
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic scan_word(input logic [IW-1:0] ch, input logic [DW-1:0] w, input int n);
        do_uir(ch);
        do_cdr();
        for (int i = 0; i < n; i++) do_sdr(i < DW ? w[i] : 1'b0);
    endtask

    task automatic read_flags(input logic [IW-1:0] ch, output logic le, output logic ov);
        do_uir(ch);
        do_cdr();
        for (int i = 0; i < CW; i++) do_sdr(1'b0);
        ov = tdo;
        do_sdr(1'b0);
        le = tdo;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (tdo !== 1'b0) begin bad++; $display("FAIL reset_tdo: got %b want 0", tdo); end
        total++; if (jdo !== '0) begin bad++; $display("FAIL reset_jdo: got %h want 0", jdo); end
        total++; if (action_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", action_valid); end
        total++; if (action_ch !== '0) begin bad++; $display("FAIL reset_ch: got %0d want 0", action_ch); end
        total++; if (st_ready_test_idle !== 1'b0) begin bad++; $display("FAIL reset_st_ready: got %b want 0", st_ready_test_idle); end
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (st_ready_test_idle !== 1'b1) begin bad++; $display("FAIL st_ready_after_reset: got %b want 1", st_ready_test_idle); end
    endtask

    task automatic test_tdo_seq;
        logic [DW-1:0] exp;
        capture_data[2*CW +: CW] = 36'h9_ABCD_1234;
        exp = {2'b00, 36'h9_ABCD_1234};
        do_uir(2'd2);
        do_cdr();
        for (int i = 0; i < DW; i++) begin
            total++;
            if (tdo !== exp[i]) begin bad++; $display("FAIL tdo_seq bit %0d: got %b want %b", i, tdo, exp[i]); end
            do_sdr(1'b0);
        end
    endtask

    task automatic test_update;
        action_ready = 1'b1;
        scan_word(2'd1, 38'h2A_5555_5555, DW);
        do_udr();
        total++; if (jdo !== 38'h2A_5555_5555) begin bad++; $display("FAIL update_jdo: got %h want 2a55555555", jdo); end
        total++; if (action_ch !== 2'd1) begin bad++; $display("FAIL update_ch: got %0d want 1", action_ch); end
        total++; if (action_valid !== 1'b1) begin bad++; $display("FAIL update_valid: got %b want 1", action_valid); end
        @(posedge clk); #1;
        total++; if (action_valid !== 1'b0) begin bad++; $display("FAIL update_valid_clear: got %b want 0", action_valid); end
        total++; if (st_ready_test_idle !== 1'b0) begin bad++; $display("FAIL update_st_ready: got %b want 0", st_ready_test_idle); end
    endtask

    task automatic test_overrun;
        logic le, ov;
        action_ready = 1'b0;
        scan_word(2'd0, WORD_A, DW);
        do_udr();
        total++; if (action_valid !== 1'b1) begin bad++; $display("FAIL ovr_first_valid: got %b want 1", action_valid); end
        total++; if (jdo !== WORD_A) begin bad++; $display("FAIL ovr_first_jdo: got %h want %h", jdo, WORD_A); end
        scan_word(2'd3, WORD_B, DW);
        do_udr();
        total++; if (jdo !== WORD_A) begin bad++; $display("FAIL ovr_drop_jdo: got %h want %h", jdo, WORD_A); end
        total++; if (action_ch !== 2'd0) begin bad++; $display("FAIL ovr_drop_ch: got %0d want 0", action_ch); end
        total++; if (action_valid !== 1'b1) begin bad++; $display("FAIL ovr_drop_valid: got %b want 1", action_valid); end
        read_flags(2'd0, le, ov);
        total++; if (ov !== 1'b1) begin bad++; $display("FAIL ovr_flag_set: got %b want 1", ov); end
        total++; if (le !== 1'b0) begin bad++; $display("FAIL ovr_len_clean: got %b want 0", le); end
        read_flags(2'd0, le, ov);
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL ovr_flag_clear: got %b want 0", ov); end
        action_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (action_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain: got %b want 0", action_valid); end
    endtask

    task automatic test_len_err;
        logic le, ov;
        action_ready = 1'b1;
        scan_word(2'd2, WORD_C, DW - 1);
        do_udr();
        total++; if (action_valid !== 1'b0) begin bad++; $display("FAIL short_valid: got %b want 0", action_valid); end
        total++; if (jdo !== WORD_A) begin bad++; $display("FAIL short_jdo: got %h want %h", jdo, WORD_A); end
        read_flags(2'd2, le, ov);
        total++; if (le !== 1'b1) begin bad++; $display("FAIL short_len_err: got %b want 1", le); end
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL short_ovr: got %b want 0", ov); end
        scan_word(2'd2, WORD_C, DW + 1);
        do_udr();
        total++; if (action_valid !== 1'b0) begin bad++; $display("FAIL long_valid: got %b want 0", action_valid); end
        total++; if (jdo !== WORD_A) begin bad++; $display("FAIL long_jdo: got %h want %h", jdo, WORD_A); end
        read_flags(2'd2, le, ov);
        total++; if (le !== 1'b1) begin bad++; $display("FAIL long_len_err: got %b want 1", le); end
    endtask

    task automatic test_back_to_back;
        action_ready = 1'b0;
        scan_word(2'd2, WORD_D, DW);
        do_udr();
        total++; if (action_valid !== 1'b1) begin bad++; $display("FAIL b2b_first_valid: got %b want 1", action_valid); end
        total++; if (jdo !== WORD_D) begin bad++; $display("FAIL b2b_first_jdo: got %h want %h", jdo, WORD_D); end
        scan_word(2'd1, WORD_E, DW);
        action_ready = 1'b1;
        do_udr();
        total++; if (action_valid !== 1'b1) begin bad++; $display("FAIL b2b_refill_valid: got %b want 1", action_valid); end
        total++; if (jdo !== WORD_E) begin bad++; $display("FAIL b2b_refill_jdo: got %h want %h", jdo, WORD_E); end
        total++; if (action_ch !== 2'd1) begin bad++; $display("FAIL b2b_refill_ch: got %0d want 1", action_ch); end
        @(posedge clk); #1;
        total++; if (action_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", action_valid); end
    endtask

    task automatic test_uir_udr;
        capture_data[0*CW +: CW] = 36'h0_0000_0000;
        capture_data[3*CW +: CW] = 36'h0_0000_0003;
        scan_word(2'd0, WORD_A, DW);
        ir_in = 2'd3;
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (action_valid !== 1'b0) begin bad++; $display("FAIL uir_udr_valid: got %b want 0", action_valid); end
        total++; if (jdo !== WORD_E) begin bad++; $display("FAIL uir_udr_jdo: got %h want %h", jdo, WORD_E); end
        do_cdr();
        total++; if (tdo !== 1'b1) begin bad++; $display("FAIL uir_udr_ir_bit0: got %b want 1", tdo); end
        do_sdr(1'b0);
        total++; if (tdo !== 1'b1) begin bad++; $display("FAIL uir_udr_ir_bit1: got %b want 1", tdo); end
        do_sdr(1'b0);
        total++; if (tdo !== 1'b0) begin bad++; $display("FAIL uir_udr_ir_bit2: got %b want 0", tdo); end
    endtask

    task automatic test_reset_mid;
        action_ready = 1'b0;
        scan_word(2'd1, WORD_B, DW);
        do_udr();
        total++; if (action_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid: got %b want 1", action_valid); end
        do_uir(2'd3);
        do_cdr();
        do_sdr(1'b1);
        total++; if (tdo !== 1'b1) begin bad++; $display("FAIL rmid_pre_tdo: got %b want 1", tdo); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (tdo !== 1'b0) begin bad++; $display("FAIL rmid_tdo: got %b want 0", tdo); end
        total++; if (jdo !== '0) begin bad++; $display("FAIL rmid_jdo: got %h want 0", jdo); end
        total++; if (action_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", action_valid); end
        total++; if (action_ch !== '0) begin bad++; $display("FAIL rmid_ch: got %0d want 0", action_ch); end
        total++; if (st_ready_test_idle !== 1'b0) begin bad++; $display("FAIL rmid_st_ready: got %b want 0", st_ready_test_idle); end
        action_ready = 1'b1;
        do_udr();
        total++; if (action_valid !== 1'b0) begin bad++; $display("FAIL rmid_udr_valid: got %b want 0", action_valid); end
        total++; if (jdo !== '0) begin bad++; $display("FAIL rmid_udr_jdo: got %h want 0", jdo); end
    endtask

    initial begin
        reset = 1'b1; scan_en = 1'b0;
        vs_uir = 1'b0; vs_cdr = 1'b0; vs_sdr = 1'b0; vs_udr = 1'b0;
        jtag_state_rti = 1'b1; ir_in = '0; tdi = 1'b0;
        capture_data = '0; action_ready = 1'b0;
        test_reset();
        test_tdo_seq();
        test_update();
        test_overrun();
        test_len_err();
        test_back_to_back();
        test_uir_udr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_dbg_scan_slave.md
# nios_dbg_scan_slave

Parametrised single-clock debug scan slave for the Nios II debug path: it decodes a strobe-based virtual-JTAG scan interface, captures per-channel status into a shift register, and shifts TDI/TDO. On a complete update it hands the scanned word and its channel index to the CPU-side debug logic through a one-deep valid/ready slot. It generalises the fixed 2-bit-IR, 38-bit debug slave to NUM_CH channels and arbitrary DR width. It adds scan-length checking, overrun detection and backpressure.

## Interface
- DR_WIDTH, 38: data-register / jdo width, ≥ 4.
- IR_WIDTH, 2: instruction width; NUM_CH = 2**IR_WIDTH channels.
- CAP_W, derived = DR_WIDTH-2: capture payload bits per channel.
- clk  in  1  system clock; all scan strobes are synchronous to it.
- reset  in  1  synchronous, active-high reset.
- scan_en  in  1  qualifies every strobe below (one-cycle TCK-edge enable).
- vs_uir, vs_cdr, vs_sdr, vs_udr  in  1 each  update-IR, capture-DR, shift-DR, update-DR strobes.
- jtag_state_rti  in  1  TAP in Run-Test/Idle.
- ir_in  in  IR_WIDTH  instruction, sampled on vs_uir.
- tdi  in  1  serial data in.
- capture_data  in  NUM_CH*CAP_W  per-channel capture payload; channel k at [k*CAP_W +: CAP_W].
- action_ready  in  1  consumer accepts the pending action.
- tdo  out  1  serial data out = sr[0].
- jdo  out  DR_WIDTH  last accepted update word.
- action_valid  out  1  action pending.
- action_ch  out  IR_WIDTH  channel of pending action.
- st_ready_test_idle  out  1  registered jtag_state_rti & !action_valid.

## Operation
- A strobe acts only when scan_en=1. Priority when several strobes coincide: uir > udr > cdr > sdr. Only the winning strobe acts.
- States are IDLE and SHIFT. Reset enters IDLE.
- vs_uir: ir_q <= ir_in. The state goes to IDLE.
- vs_cdr, from any state:
  - sr <= {len_err, overrun, capture_data slice[ir_q]}, with the MSB first.
  - shift_cnt <= 0.
  - The state goes to SHIFT.
  - len_err and overrun clear in the same cycle, because they have just been reported.
- vs_sdr, in SHIFT: sr <= {tdi, sr[DR_WIDTH-1:1]}. shift_cnt increments and saturates at its all-ones value. In IDLE, vs_sdr is ignored.
- vs_udr, in SHIFT, the state returns to IDLE and one of three cases applies:
  - shift_cnt ≠ DR_WIDTH: len_err <= 1. The update is dropped.
  - Slot occupied and action_ready=0: overrun <= 1. The update is dropped and jdo is unchanged.
  - Otherwise: jdo <= sr, action_ch <= ir_q, action_valid <= 1.
- vs_udr in IDLE is ignored, with no flags set.
- Slot handshake:
  - action_valid clears on the cycle after a cycle with action_valid & action_ready.
  - A udr arriving in the same cycle as acceptance refills the slot; action_valid stays 1.
- Sticky flags: when a set and a clear occur in the same cycle, the set wins.
- Reset values: tdo 0, jdo 0, action_valid 0, action_ch 0, st_ready_test_idle 0. Internally sr 0, ir_q 0, shift_cnt 0, len_err 0, overrun 0, state IDLE.

## Timing
- All outputs are registered or driven directly from registers.
- tdo reflects the new sr[0] one cycle after the cdr or sdr strobe.
- jdo, action_valid and action_ch update one cycle after the accepted udr strobe.
- st_ready_test_idle lags jtag_state_rti and action_valid by one cycle.
- Throughput: one accepted update per udr. Consecutive scans never stall the scan side; excess updates are dropped and flagged.
- Reset asserted mid-scan or mid-handshake returns every register to its reset value on the next edge. Any pending action is lost.

## Structure
- Package nios_dbg_pkg contains:
  - the state enum (IDLE, SHIFT);
  - status bit positions STAT_LEN_ERR = DR_WIDTH-1 and STAT_OVERRUN = DR_WIDTH-2, expressed as offsets from the MSB;
  - the width function for shift_cnt, $clog2(DR_WIDTH+2).
- Sub-module nios_dbg_action_slot is the one-deep valid/ready holding register for jdo and action_ch. It has a push/full interface toward the scan FSM.

## Test plan
- Reset, then ir_in=2 on uir, capture_data slice 2 = 36'h9_ABCD_1234, cdr, then 38 sdr with tdi=0 → the tdo sequence LSB-first is 36'h9ABCD1234 followed by 0,0 (flags).
- Full 38-bit scan of 38'h2A_5555_5555 on channel 1, then udr with action_ready=1 → the next cycle gives jdo=38'h2A55555555, action_ch=1, action_valid=1; it clears one cycle after.
- With action_ready=0, two complete scans and updates → the second is dropped and jdo holds the first word. The next cdr captures overrun=1 (sr[36]), and overrun reads 0 on the following capture.
- A scan of 37 shifts then udr → no action and jdo unchanged; the next cdr captures len_err=1 (sr[37]). A scan of 39 shifts gives the same result.
- udr in the same cycle as action_valid&action_ready → action_valid stays 1 and jdo takes the new word. Asserting uir and udr together → only ir_q updates.
- Reset pulsed during SHIFT with action_valid=1 → all outputs read 0 next cycle. A subsequent udr without cdr is ignored.
